// File: rtl/fp32_align_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_align_stage
//  Purpose  : Pre-normalisation front end of the vecunit FP32 adder. Unpacks
//             two IEEE-754 singles, decides which operand has the larger
//             magnitude, and right-aligns the smaller significand with
//             guard/round/sticky bits. Two registered stages with
//             valid/ready flow control so the adder can stall.
//  Ports    : clk_i, rst_i           - clock, synchronous active-high reset
//             in_valid_i/in_ready_o  - operand pair handshake
//             op_a_i, op_b_i         - raw IEEE-754 single operands
//             out_valid_o/out_ready_i- aligned result handshake
//             swap_o                 - 1 when B is the larger magnitude
//             exp_large_o            - effective exponent of larger operand
//             sign_large_o/small_o   - operand signs after swap
//             mant_large_o           - larger significand, hidden bit incl.
//             mant_small_o           - aligned smaller significand, LSB=sticky
//             special_o              - (FP_ALIGN_SPECIAL_EN only) Inf/NaN class
//  Options  : `define FP_ALIGN_SPECIAL_EN to add special-operand detection.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_align_stage #(
    parameter int SHIFT_W = 27
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        op_a_i,
    input  logic [31:0]        op_b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               swap_o,
    output logic [7:0]         exp_large_o,
    output logic               sign_large_o,
    output logic               sign_small_o,
    output logic [23:0]        mant_large_o,
    output logic [SHIFT_W-1:0] mant_small_o
`ifdef FP_ALIGN_SPECIAL_EN
    ,
    output logic [1:0]         special_o
`endif
);

    // Shift distances at or beyond this push every significand bit into sticky.
    localparam logic [7:0]         c_SAT_DIFF = 8'(SHIFT_W);
    localparam logic [SHIFT_W-1:0] c_ONE      = {{(SHIFT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or its consumer
    // is taking its current contents this cycle.
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv    = !r_s2_valid | out_ready_i;
    assign w_s1_adv    = !r_s1_valid | w_s2_adv;
    assign in_ready_o  = w_s1_adv;
    assign out_valid_o = r_s2_valid;

    // ------------------------------------------------------------------
    // Unpack and compare (feeds stage 1)
    // ------------------------------------------------------------------
    logic [7:0]  w_exp_a, w_exp_b;
    logic [7:0]  w_eff_a, w_eff_b;
    logic [23:0] w_sig_a, w_sig_b;
    logic        w_swap;
    logic [7:0]  w_exp_large, w_exp_small;

    assign w_exp_a = op_a_i[30:23];
    assign w_exp_b = op_b_i[30:23];
    // Denormals share the exponent of the smallest normal, without hidden bit.
    assign w_eff_a = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
    assign w_eff_b = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
    assign w_sig_a = {(w_exp_a != 8'd0), op_a_i[22:0]};
    assign w_sig_b = {(w_exp_b != 8'd0), op_b_i[22:0]};

    // Ties keep A as the larger operand, so equal inputs never swap.
    assign w_swap      = (w_eff_b > w_eff_a) | ((w_eff_b == w_eff_a) & (w_sig_b > w_sig_a));
    assign w_exp_large = w_swap ? w_eff_b : w_eff_a;
    assign w_exp_small = w_swap ? w_eff_a : w_eff_b;

`ifdef FP_ALIGN_SPECIAL_EN
    logic       w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [1:0] w_special;
    assign w_nan_a = (&w_exp_a) & (|op_a_i[22:0]);
    assign w_nan_b = (&w_exp_b) & (|op_b_i[22:0]);
    assign w_inf_a = (&w_exp_a) & ~(|op_a_i[22:0]);
    assign w_inf_b = (&w_exp_b) & ~(|op_b_i[22:0]);
    // NaN dominates; Inf - Inf is flagged invalid ahead of plain Inf.
    assign w_special = (w_nan_a | w_nan_b)                          ? 2'b10 :
                       (w_inf_a & w_inf_b & (op_a_i[31] ^ op_b_i[31])) ? 2'b11 :
                       (w_inf_a | w_inf_b)                          ? 2'b01 : 2'b00;
`endif

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic        r_s1_swap;
    logic [7:0]  r_s1_exp_large;
    logic [7:0]  r_s1_diff;
    logic        r_s1_sign_large;
    logic        r_s1_sign_small;
    logic [23:0] r_s1_mant_large;
    logic [23:0] r_s1_sig_small;
`ifdef FP_ALIGN_SPECIAL_EN
    logic [1:0]  r_s1_special;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid      <= 1'b0;
            r_s1_swap       <= 1'b0;
            r_s1_exp_large  <= 8'd0;
            r_s1_diff       <= 8'd0;
            r_s1_sign_large <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_mant_large <= 24'd0;
            r_s1_sig_small  <= 24'd0;
`ifdef FP_ALIGN_SPECIAL_EN
            r_s1_special    <= 2'b00;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_swap       <= w_swap;
                r_s1_exp_large  <= w_exp_large;
                r_s1_diff       <= w_exp_large - w_exp_small;
                r_s1_sign_large <= w_swap ? op_b_i[31] : op_a_i[31];
                r_s1_sign_small <= w_swap ? op_a_i[31] : op_b_i[31];
                r_s1_mant_large <= w_swap ? w_sig_b : w_sig_a;
                r_s1_sig_small  <= w_swap ? w_sig_a : w_sig_b;
`ifdef FP_ALIGN_SPECIAL_EN
                r_s1_special    <= w_special;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment shifter with sticky collection (feeds stage 2)
    // ------------------------------------------------------------------
    logic [SHIFT_W-1:0] w_ext;
    logic               w_sat;
    logic [4:0]         w_shamt;
    logic [SHIFT_W-1:0] w_shifted;
    logic [SHIFT_W-1:0] w_lost_mask;
    logic               w_sticky;
    logic [SHIFT_W-1:0] w_mant_small;

    assign w_ext       = {r_s1_sig_small, 3'b000};
    assign w_sat       = (r_s1_diff >= c_SAT_DIFF);
    // Below saturation the distance is at most 26, so 5 bits suffice.
    assign w_shamt     = r_s1_diff[4:0];
    assign w_shifted   = w_ext >> w_shamt;
    assign w_lost_mask = (c_ONE << w_shamt) - c_ONE;
    assign w_sticky    = |(w_ext & w_lost_mask);
    // A zero significand must never produce a sticky bit, saturated or not.
    assign w_mant_small = w_sat ? {{(SHIFT_W-1){1'b0}}, |r_s1_sig_small}
                                : {w_shifted[SHIFT_W-1:1], w_shifted[0] | w_sticky};

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid   <= 1'b0;
            swap_o       <= 1'b0;
            exp_large_o  <= 8'd0;
            sign_large_o <= 1'b0;
            sign_small_o <= 1'b0;
            mant_large_o <= 24'd0;
            mant_small_o <= '0;
`ifdef FP_ALIGN_SPECIAL_EN
            special_o    <= 2'b00;
`endif
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                swap_o       <= r_s1_swap;
                exp_large_o  <= r_s1_exp_large;
                sign_large_o <= r_s1_sign_large;
                sign_small_o <= r_s1_sign_small;
                mant_large_o <= r_s1_mant_large;
                mant_small_o <= w_mant_small;
`ifdef FP_ALIGN_SPECIAL_EN
                special_o    <= r_s1_special;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_align_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_align_stage
//  Purpose  : Self-checking bench for fp32_align_stage. A scoreboard queue of
//             expected results, computed from IEEE-754 magnitude rules, is
//             compared against every output beat (including stalled beats).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_align_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic        swap_o;
    logic [7:0]  exp_large_o;
    logic        sign_large_o;
    logic        sign_small_o;
    logic [23:0] mant_large_o;
    logic [26:0] mant_small_o;
`ifdef FP_ALIGN_SPECIAL_EN
    logic [1:0]  special_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pop    = 0;
    logic [63:0] r_sb_q[$];

    fp32_align_stage #(.SHIFT_W(27)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .swap_o       (swap_o),
        .exp_large_o  (exp_large_o),
        .sign_large_o (sign_large_o),
        .sign_small_o (sign_small_o),
        .mant_large_o (mant_large_o),
        .mant_small_o (mant_small_o)
`ifdef FP_ALIGN_SPECIAL_EN
        ,
        .special_o    (special_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: larger magnitude found by comparing the raw |x| bit patterns,
    // alignment done with integer divide/modulo by a power of two.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        sw;
        logic [31:0] l, s;
        int          el, es, d;
        longint      sig_l, sig_s, v, ms, pw;
        logic [1:0]  sp;
        sw    = (b[30:0] > a[30:0]);
        l     = sw ? b : a;
        s     = sw ? a : b;
        el    = (l[30:23] == 8'd0) ? 1 : int'(l[30:23]);
        es    = (s[30:23] == 8'd0) ? 1 : int'(s[30:23]);
        sig_l = ((l[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(l[22:0]);
        sig_s = ((s[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(s[22:0]);
        v     = sig_s * 8;
        d     = el - es;
        if (d >= 27) begin
            ms = (sig_s != 0) ? 1 : 0;
        end else begin
            pw = longint'(1) << d;
            ms = (v / pw) | (((v % pw) != 0) ? 1 : 0);
        end
        sp = 2'b00;
`ifdef FP_ALIGN_SPECIAL_EN
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            sp = 2'b10;
        else if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31])
            sp = 2'b11;
        else if (a[30:0] == 31'h7F800000 || b[30:0] == 31'h7F800000)
            sp = 2'b01;
`endif
        return {sp, sw, 8'(el), l[31], s[31], 24'(sig_l), 27'(ms)};
    endfunction

    function automatic logic [63:0] observed();
        logic [1:0] sp;
        sp = 2'b00;
`ifdef FP_ALIGN_SPECIAL_EN
        sp = special_o;
`endif
        return {sp, swap_o, exp_large_o, sign_large_o, sign_small_o, mant_large_o, mant_small_o};
    endfunction

    // Scoreboard: every valid output beat (stalled or not) must equal the head.
    always @(negedge clk_i) begin
        if (rst_i) begin
            r_sb_q.delete();
        end else begin
            if (out_valid_o) begin
                if (r_sb_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    check("result", observed(), r_sb_q[0]);
                    if (out_ready_i) begin
                        void'(r_sb_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (in_valid_i && in_ready_o)
                r_sb_q.push_back(model(op_a_i, op_b_i));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        in_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic exp_swap, input logic [7:0] exp_el,
                            input logic [23:0] exp_ml, input logic [26:0] exp_ms);
        int n = 0;
        send(a, b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            n++;
            if (out_valid_o) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_swap"}, 64'(swap_o), 64'(exp_swap));
        check({tag, "_exp_large"}, 64'(exp_large_o), 64'(exp_el));
        check({tag, "_mant_large"}, 64'(mant_large_o), 64'(exp_ml));
        check({tag, "_mant_small"}, 64'(mant_small_o), 64'(exp_ms));
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r = r;
            1: r = {r[31], 31'd0};
            2: r = {r[31], 8'd0, r[22:0]};
            3: r = {r[31], 8'(120 + $urandom_range(0, 15)), r[22:0]};
            default: r = {r[31], 8'hFF, (r[0] ? 23'd0 : r[22:0])};
        endcase
        return r;
    endfunction

    initial begin
        int pop0;
        // Reset state
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_data", observed(), 64'd0);
        @(posedge clk_i);
        #1;

        // Directed vectors
        directed("t_3_vs_1", 32'h40400000, 32'h3F800000, 1'b0, 8'd128, 24'hC00000, 27'h2000000);
        directed("t_1_vs_3", 32'h3F800000, 32'h40400000, 1'b1, 8'd128, 24'hC00000, 27'h2000000);
        check("t_1_vs_3_sign_large", 64'(sign_large_o), 64'd0);
        directed("t_diff24", 32'h4B800000, 32'h3F800001, 1'b0, 8'd151, 24'h800000, 27'h5);
        directed("t_sat", 32'h64000000, 32'h3F800000, 1'b0, 8'd200, 24'h800000, 27'h1);
        directed("t_sat_zero", 32'h64000000, 32'h00000000, 1'b0, 8'd200, 24'h800000, 27'h0);
        directed("t_equal", 32'h41200000, 32'h41200000, 1'b0, 8'd130, 24'hA00000, 27'h5000000);
        directed("t_zeros", 32'h00000000, 32'h80000000, 1'b0, 8'd1, 24'h000000, 27'h0);

        // Backpressure: four back-to-back pairs, consumer stalls 3 cycles
        pop0 = n_pop;
        out_ready_i = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand_op(), rand_op());
            end
            begin
                bit seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk_i);
                    if (out_valid_o) begin
                        seen = 1;
                        break;
                    end
                end
                check("bp_out_valid_seen", 64'(seen), 64'd1);
                check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
                repeat (3) @(posedge clk_i);
                #1 out_ready_i = 1'b1;
            end
        join
        repeat (6) @(posedge clk_i);
        #1;
        check("bp_count", 64'(n_pop - pop0), 64'd4);
        check("bp_drained", 64'(r_sb_q.size()), 64'd0);

        // Reset with both stages full
        out_ready_i = 1'b0;
        send(32'h40000000, 32'h3F000000);
        send(32'h42000000, 32'hC1000000);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst2_out_valid", 64'(out_valid_o), 64'd0);
        check("rst2_in_ready", 64'(in_ready_o), 64'd1);
        check("rst2_data", observed(), 64'd0);
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
        directed("t_after_rst", 32'h40400000, 32'h3F800000, 1'b0, 8'd128, 24'hC00000, 27'h2000000);

        // Randomized traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            op_a_i      = rand_op();
            op_b_i      = ($urandom_range(0, 7) == 0) ? op_a_i : rand_op();
            @(posedge clk_i);
            #1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        check("final_drained", 64'(r_sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
